line_clear_seq: RTL
===================

// Module: line_clear_seq
// PURPOSE
//  Sequencer that removes completed lines from the board RAM after a piece locks. On start it
//  scans rows bottom (Y_SIZE-1) to top (0) one row at a time and drops full rows by copying each
//  surviving row down to a write pointer. It then fills the vacated top rows with EMPTY and
//  reports the line count to score keeping. Sits between the game-control FSM and the board RAM.
// PARAMETERS
//  X_SIZE      10  cells per row
//  Y_SIZE      20  rows; row 0 = top, row Y_SIZE-1 = bottom
//  COLOR_W     3   bits per cell (block_color encoding)
//  EMPTY_CODE  0   block_color value meaning empty cell
//  ROW_W       X_SIZE*COLOR_W  row bus width (derived, localparam); cell c = bits [c*COLOR_W +: COLOR_W]
// PORTS
//  Clk            in   1      clock, all state on rising edge
//  Reset_n        in   1      asynchronous active-low reset
//  start          in   1      request a clear pass; sampled only in IDLE
//  busy           out  1      high in every state except IDLE
//  done           out  1      one-cycle pulse when pass complete
//  lines_cleared  out  5      full rows removed in last pass; held until next accepted start
//  rd_en          out  1      board RAM read strobe
//  rd_addr        out  5      row address for read
//  rd_data        in   ROW_W  row data; valid the cycle after rd_en (1-cycle sync RAM)
//  wr_en          out  1      board RAM write strobe
//  wr_addr        out  5      row address for write
//  wr_data        out  ROW_W  row data to write
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, lines_cleared=0, rd_en=0, wr_en=0, addrs/wr_data=0; rd_row,wr_row=Y_SIZE-1.
//  Reset mid-pass aborts immediately; RAM keeps whatever was written so far; no done pulse.
//  States: IDLE -> READ -> EVAL -> (READ | FILL | DONE); FILL -> (FILL | DONE); DONE -> IDLE.
//  IDLE: on start=1 clear lines_cleared, rd_row=wr_row=Y_SIZE-1, go READ. start otherwise ignored.
//  READ: rd_en=1, rd_addr=rd_row; go EVAL.
//  EVAL: row is full iff every cell != EMPTY_CODE.
//   full: lines_cleared+=1, no write, wr_row unchanged.
//   not full: if wr_row!=rd_row then wr_en=1, wr_addr=wr_row, wr_data=rd_data; wr_row-=1 in both cases
//   (no write when pointers equal: row already in place).
//   then if rd_row==0: go FILL if lines_cleared (incl. this row) >0, else DONE; else rd_row-=1, go READ.
//  FILL: wr_en=1, wr_addr=wr_row, wr_data=all cells EMPTY_CODE; if wr_row==0 go DONE else wr_row-=1.
//   Exactly lines_cleared FILL cycles (rows 0..L-1).
//  DONE: done=1 for this cycle only, busy=1; go IDLE. start here is ignored (not queued).
//  start while busy: ignored, no effect on pass.
//  rd_en and wr_en never both high in one cycle; strobes are combinational from state, addrs/data registered-clean.
//  Latency: with start accepted at edge 0, READ/EVAL occupy cycles 1..2*Y_SIZE, FILL next L cycles,
//   done high in cycle 2*Y_SIZE+L+1; busy high cycles 1..2*Y_SIZE+L+1.
//  lines_cleared range 0..Y_SIZE, 5 bits, no wrap; game logic consumes 0..4.
//  Pointers are 5-bit unsigned; wr_row never decremented below 0 (FILL exits at 0; EVAL decrement at
//   wr_row==0 only occurs on last row with L=0, going DONE, pointer value then don't-care).
// TESTING
//  1 Empty board, start -> no wr_en ever, 20 rd_en, lines_cleared=0, done at cycle 41, busy cycles 1..41.
//  2 Row19 full, row18=pattern A, rest empty -> writes row19=A, rows18..1 copied down, row0=EMPTY;
//    lines_cleared=1, done at cycle 42.
//  3 Rows16..19 full, row15=B -> row19=B, rows0..3 EMPTY, lines_cleared=4, done at cycle 45.
//  4 Rows19,17 full, row18=A, row16=B -> row19=A, row18=B, rows0..1 EMPTY, lines_cleared=2; no write
//    issued in any EVAL where wr_row==rd_row (check none before row 18 read).
//  5 start pulsed during READ of row 10 and during DONE -> ignored; exactly one done pulse per accepted start.
//  6 Reset_n low in FILL (async, mid-cycle) -> all outputs 0 immediately, state IDLE; next start runs clean pass.

Source files
------------

// File: rtl/line_clear_seq.sv
// ---------------------------------------------------------------------------
// line_clear_seq
//
// Removes completed lines from the board RAM after a piece locks. A pass
// scans the rows from the bottom (Y_SIZE-1) to the top (0), one row per
// READ/EVAL pair. Each surviving row is copied down to a write pointer and
// each full row is dropped. The vacated top rows are then filled with
// EMPTY_CODE, and the number of dropped rows is reported.
//
// Ports
//   Clk            clock; all state changes on the rising edge
//   Reset_n        asynchronous active-low reset
//   start          request a clear pass (sampled only while idle)
//   busy           high in every state except IDLE
//   done           one-cycle pulse when a pass completes
//   lines_cleared  full rows removed in the last pass, held until next start
//   rd_en/rd_addr  board RAM read strobe and row address
//   rd_data        row data, valid the cycle after rd_en (1-cycle sync RAM)
//   wr_en/wr_addr  board RAM write strobe and row address
//   wr_data        row data to write
//
// Row layout: cell c occupies rd_data/wr_data bits [c*COLOR_W +: COLOR_W].
// ---------------------------------------------------------------------------
module line_clear_seq #(
  parameter  int X_SIZE     = 10,
  parameter  int Y_SIZE     = 20,
  parameter  int COLOR_W    = 3,
  parameter  int EMPTY_CODE = 0,
  localparam int ROW_W      = X_SIZE * COLOR_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [4:0]       lines_cleared,
  output logic             rd_en,
  output logic [4:0]       rd_addr,
  input  logic [ROW_W-1:0] rd_data,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [ROW_W-1:0] wr_data
);

  localparam logic [4:0]         LAST_ROW = 5'(Y_SIZE - 1);
  localparam logic [COLOR_W-1:0] EMPTY_C  = COLOR_W'(EMPTY_CODE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_FILL,
    S_DONE
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] rd_row_q, rd_row_d;
  logic [4:0] wr_row_q, wr_row_d;
  logic [4:0] lines_q, lines_d;

  // -------------------------------------------------------------------------
  // Row classification: a row is full when no cell holds the empty code.
  // The all-empty row pattern is used for the FILL writes.
  // -------------------------------------------------------------------------
  logic [X_SIZE-1:0] cell_used;
  logic [ROW_W-1:0]  empty_row;
  logic              row_full;

  generate
    for (genvar gi = 0; gi < X_SIZE; gi++) begin : g_cell
      assign cell_used[gi]                      = (rd_data[gi*COLOR_W +: COLOR_W] != EMPTY_C);
      assign empty_row[gi*COLOR_W +: COLOR_W]   = EMPTY_C;
    end
  endgenerate

  assign row_full = &cell_used;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    rd_row_d = rd_row_q;
    wr_row_d = wr_row_q;
    lines_d  = lines_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          lines_d  = '0;
          rd_row_d = LAST_ROW;
          wr_row_d = LAST_ROW;
          state_d  = S_READ;
        end
      end

      S_READ: state_d = S_EVAL;

      S_EVAL: begin
        // rd_data holds the row addressed in the preceding READ cycle.
        if (row_full) begin
          lines_d = lines_q + 5'd1;
        end else begin
          // The survivor lands at wr_row (write suppressed when already
          // in place); either way the next survivor goes one row higher.
          // At row 0 with no lines cleared this wraps, but the pass ends.
          wr_row_d = wr_row_q - 5'd1;
        end

        if (rd_row_q == 5'd0) begin
          state_d = (lines_d != 5'd0) ? S_FILL : S_DONE;
        end else begin
          rd_row_d = rd_row_q - 5'd1;
          state_d  = S_READ;
        end
      end

      S_FILL: begin
        // wr_row entered FILL at L-1, so this runs exactly L cycles.
        if (wr_row_q == 5'd0) begin
          state_d = S_DONE;
        end else begin
          wr_row_d = wr_row_q - 5'd1;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      rd_row_q <= LAST_ROW;
      wr_row_q <= LAST_ROW;
      lines_q  <= '0;
    end else begin
      state_q  <= state_d;
      rd_row_q <= rd_row_d;
      wr_row_q <= wr_row_d;
      lines_q  <= lines_d;
    end
  end

  // -------------------------------------------------------------------------
  // Output decode. Strobes come straight from the registered state so the
  // RAM sees the read in READ and the data arrives in EVAL. Address and
  // data buses are forced to zero whenever their strobe is low.
  // -------------------------------------------------------------------------
  logic eval_copy;
  logic fill_wr;

  always_comb begin
    eval_copy = (state_q == S_EVAL) && !row_full && (wr_row_q != rd_row_q);
    fill_wr   = (state_q == S_FILL);

    rd_en     = (state_q == S_READ);
    rd_addr   = rd_en ? rd_row_q : 5'd0;

    wr_en     = eval_copy || fill_wr;
    wr_addr   = wr_en ? wr_row_q : 5'd0;
    wr_data   = '0;
    if (eval_copy) begin
      wr_data = rd_data;
    end else if (fill_wr) begin
      wr_data = empty_row;
    end

    busy          = (state_q != S_IDLE);
    done          = (state_q == S_DONE);
    lines_cleared = lines_q;
  end

endmodule
